ibex_dffram_arbiter: RTL and testbench

- Upstream of the single-port DFFRAM macro.
- Accepts the Ibex instruction-fetch and LSU data request/grant/rvalid interfaces and arbitrates them onto the one RAM port.
- Generates the 1-cycle-latency rvalid/rdata/err responses.
- Flags accesses outside the RAM window as bus errors without touching the RAM.

---
 rtl/ibex_dffram_arbiter.sv | 140 ++++++++++++++
 tb/tb_ibex_dffram_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_dffram_arbiter.sv
// ibex_dffram_arbiter
//   Puts the Ibex instruction-fetch port and the LSU data port onto the one
//   port of a single-port DFFRAM macro. Requests are granted combinationally
//   in the cycle they are raised. Responses (rvalid/rdata/err) come back
//   exactly one cycle after the grant. Accesses outside the RAM window are
//   granted, but the RAM is not enabled and the response carries err=1.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   instr_*                fetch req/addr in; gnt/rvalid/rdata/err out
//   data_*                 LSU req/we/be/addr/wdata in; gnt/rvalid/rdata/err out
//   ram_en_o, ram_we_o     RAM chip enable and byte write mask
//   ram_a_o, ram_di_o      RAM word address and write data
//   ram_do_i               RAM read data, valid the cycle after ram_en_o
module ibex_dffram_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          AW         = 12,
  parameter int          STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,

  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,

  output logic          ram_en_o,
  output logic [3:0]    ram_we_o,
  output logic [31:0]   ram_di_o,
  output logic [AW-1:0] ram_a_o,
  input  logic [31:0]   ram_do_i
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  // Port that owns the response slot in the following cycle.
  localparam logic [1:0] PORT_NONE  = 2'd0;
  localparam logic [1:0] PORT_INSTR = 2'd1;
  localparam logic [1:0] PORT_DATA  = 2'd2;

  logic [CW-1:0] starve_q, starve_d;
  logic [1:0]    port_q, port_d;
  logic          err_q, err_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          dataGnt, instrGnt, anyGnt;
  logic [31:0]   reqAddr;
  logic          inRange, hit, wr;
  logic [31:0]   respRdata;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^reqAddr[1:0];

  // Data has priority except when instr has been denied STARVE_MAX cycles in
  // a row. Grants are gated by reset so nothing is accepted while in reset.
  always_comb begin
    dataGnt  = rst_ni & data_req_i & ~(instr_req_i & (starve_q == STARVE_LIM));
    instrGnt = rst_ni & instr_req_i & ~dataGnt;
    anyGnt   = dataGnt | instrGnt;
    reqAddr  = dataGnt ? data_addr_i : instr_addr_i;
    inRange  = (reqAddr[31:AW+2] == BASE_ADDR[31:AW+2]);
    hit      = anyGnt & inRange;
    wr       = dataGnt & data_we_i;
  end

  // Address and write data hold their last in-range values when the RAM is
  // idle, so the macro inputs do not toggle needlessly.
  always_comb begin
    ram_en_o = hit;
    ram_we_o = (hit & wr) ? data_be_i : 4'b0000;
    ram_a_o  = hit ? reqAddr[AW+1:2] : addr_q;
    ram_di_o = (hit & wr) ? data_wdata_i : wdata_q;
  end

  always_comb begin
    starve_d = starve_q;
    if (!instr_req_i || instrGnt) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + CW'(1);
    end

    port_d = PORT_NONE;
    if (dataGnt) begin
      port_d = PORT_DATA;
    end else if (instrGnt) begin
      port_d = PORT_INSTR;
    end
    err_d = anyGnt & ~inRange;
    rd_d  = ~wr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
      port_q   <= PORT_NONE;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      port_q   <= port_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      addr_q   <= ram_a_o;
      wdata_q  <= ram_di_o;
    end
  end

  // Read data passes straight from the macro; writes and errors return 0.
  always_comb begin
    respRdata      = (rd_q & ~err_q) ? ram_do_i : 32'h0;
    instr_gnt_o    = instrGnt;
    data_gnt_o     = dataGnt;
    instr_rvalid_o = (port_q == PORT_INSTR);
    data_rvalid_o  = (port_q == PORT_DATA);
    instr_err_o    = instr_rvalid_o & err_q;
    data_err_o     = data_rvalid_o & err_q;
    instr_rdata_o  = instr_rvalid_o ? respRdata : 32'h0;
    data_rdata_o   = data_rvalid_o ? respRdata : 32'h0;
  end

endmodule

// File: tb/tb_ibex_dffram_arbiter.sv
// tb_ibex_dffram_arbiter
//   Directed and randomized stimulus for ibex_dffram_arbiter. A behavioural
//   RAM macro answers the DUT's RAM port, and a separate reference memory plus
//   a transaction-level model predicts every grant and response.
module tb_ibex_dffram_arbiter;

  localparam int AW    = 12;
  localparam int SMAX  = 4;
  localparam int WORDS = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_req;
  logic [31:0]   instr_addr;
  logic          instr_gnt, instr_rvalid, instr_err;
  logic [31:0]   instr_rdata;
  logic          data_req, data_we;
  logic [3:0]    data_be;
  logic [31:0]   data_addr, data_wdata;
  logic          data_gnt, data_rvalid, data_err;
  logic [31:0]   data_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [31:0]   ram_di;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_do;

  int compared   = 0;
  int mismatched = 0;

  // RAM macro model driven only by the DUT's RAM port.
  logic [31:0] ramMem [0:WORDS-1];
  // Reference contents updated only by the bench's own model.
  logic [31:0] refMem [0:WORDS-1];

  // Transaction-level model state.
  int          starve;
  int          pendPort;
  logic        pendErr;
  logic [31:0] pendData;
  logic [AW-1:0] lastA;
  bit          aValid;
  logic [31:0] lastDi;
  bit          diValid;

  // Per-cycle decisions made by applyStimulus and consumed by commitCycle.
  bit          curRstn, expI, expD, expIn, expWr;
  logic [31:0] curAddr;

  ibex_dffram_arbiter #(.BASE_ADDR(32'h0), .AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_di_o(ram_di),
    .ram_a_o(ram_a), .ram_do_i(ram_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      ram_do <= ramMem[ram_a];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) ramMem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and check everything the
  // model predicts for this cycle.
  task automatic applyStimulus(input bit rstn, input bit ireq, input logic [31:0] iaddr,
                               input bit dreq, input bit dwe, input logic [3:0] dbe,
                               input logic [31:0] daddr, input logic [31:0] dwdata);
    bit ivExp, dvExp;
    @(negedge clk);
    rst_n = rstn; instr_req = ireq; instr_addr = iaddr;
    data_req = dreq; data_we = dwe; data_be = dbe;
    data_addr = daddr; data_wdata = dwdata;
    #1;
    curRstn = rstn;
    if (!rstn) begin
      pendPort = 0;
      starve   = 0;
    end
    expD    = rstn && dreq && !(ireq && starve == SMAX);
    expI    = rstn && ireq && !expD;
    curAddr = expD ? daddr : iaddr;
    expIn   = (curAddr >> (AW + 2)) == 0;
    expWr   = expD && dwe;

    checkOutput("instr_gnt", instr_gnt, expI);
    checkOutput("data_gnt", data_gnt, expD);
    checkOutput("ram_en", ram_en, (expI || expD) && expIn);
    checkOutput("ram_we", ram_we, (expWr && expIn) ? dbe : 4'b0);
    if ((expI || expD) && expIn) begin
      checkOutput("ram_a", ram_a, curAddr[AW+1:2]);
    end else if (aValid && rstn) begin
      checkOutput("ram_a_hold", ram_a, lastA);
    end
    if (expWr && expIn) begin
      checkOutput("ram_di", ram_di, dwdata);
    end else if (diValid && rstn) begin
      checkOutput("ram_di_hold", ram_di, lastDi);
    end

    ivExp = (pendPort == 1);
    dvExp = (pendPort == 2);
    checkOutput("instr_rvalid", instr_rvalid, ivExp);
    checkOutput("data_rvalid", data_rvalid, dvExp);
    checkOutput("instr_err", instr_err, ivExp ? pendErr : 1'b0);
    checkOutput("data_err", data_err, dvExp ? pendErr : 1'b0);
    checkOutput("instr_rdata", instr_rdata, ivExp ? pendData : 32'h0);
    checkOutput("data_rdata", data_rdata, dvExp ? pendData : 32'h0);
  endtask

  // Advance through the rising edge and update the model.
  task automatic commitCycle();
    int idx;
    @(posedge clk);
    if (!curRstn) begin
      pendPort = 0; starve = 0; aValid = 0; diValid = 0;
    end else begin
      idx = int'(curAddr[AW+1:2]);
      pendPort = expD ? 2 : (expI ? 1 : 0);
      pendErr  = (expI || expD) && !expIn;
      pendData = (!expWr && expIn) ? refMem[idx] : 32'h0;
      if ((expI || expD) && expIn) begin
        aValid = 1; lastA = curAddr[AW+1:2];
      end
      if (expWr && expIn) begin
        diValid = 1; lastDi = data_wdata;
        for (int b = 0; b < 4; b++) begin
          if (data_be[b]) refMem[idx][8*b +: 8] = data_wdata[8*b +: 8];
        end
      end
      if (!instr_req || expI) starve = 0;
      else if (starve < SMAX) starve++;
    end
  endtask

  task automatic doCycle(input bit rstn, input bit ireq, input logic [31:0] iaddr,
                         input bit dreq, input bit dwe, input logic [3:0] dbe,
                         input logic [31:0] daddr, input logic [31:0] dwdata);
    applyStimulus(rstn, ireq, iaddr, dreq, dwe, dbe, daddr, dwdata);
    commitCycle();
  endtask

  function automatic logic [31:0] randAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0000_4000 + ($urandom_range(0, 255) << 2);
    if (r == 1) return 32'hFFFF_FFF0;
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  initial begin
    logic [31:0] w;
    for (int i = 0; i < WORDS; i++) begin
      w = (i < 64) ? $urandom : 32'h0;
      ramMem[i] = w;
      refMem[i] = w;
    end
    ramMem[16] = 32'hDEADBEEF; refMem[16] = 32'hDEADBEEF;
    ramMem[5]  = 32'h11223344; refMem[5]  = 32'h11223344;
    ram_do = 32'h0;
    starve = 0; pendPort = 0; pendErr = 0; pendData = 0;
    aValid = 0; diValid = 0; lastA = '0; lastDi = '0;
    rst_n = 1'b0; instr_req = 0; instr_addr = 0; data_req = 0; data_we = 0;
    data_be = 0; data_addr = 0; data_wdata = 0;

    // Reset held with both requests high.
    doCycle(0, 1, 32'h40, 1, 0, 4'h0, 32'h14, 32'h0);
    applyStimulus(0, 1, 32'h40, 1, 0, 4'h0, 32'h14, 32'h0);
    checkOutput("rst_ram_en", ram_en, 1'b0);
    commitCycle();
    // First cycle after release: data wins the contention immediately.
    applyStimulus(1, 1, 32'h40, 1, 0, 4'h0, 32'h14, 32'h0);
    checkOutput("post_rst_dgnt", data_gnt, 1'b1);
    commitCycle();
    // Instr granted once data drops.
    doCycle(1, 1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0);

    // Fetch of word 0x010.
    doCycle(1, 1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("fetch_rdata", instr_rdata, 32'hDEADBEEF);
    commitCycle();

    // Byte-masked write then read back.
    doCycle(1, 0, 32'h0, 1, 1, 4'b0101, 32'h14, 32'hAABBCCDD);
    applyStimulus(1, 0, 32'h0, 1, 0, 4'h0, 32'h14, 32'h0);
    checkOutput("wr_rvalid", data_rvalid, 1'b1);
    commitCycle();
    applyStimulus(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("be_merge", data_rdata, 32'h11BB33DD);
    commitCycle();

    // Starvation: both held; instr wins only in cycle 4.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 1, 32'h40, 1, 0, 4'h0, 32'h14, 32'h0);
      checkOutput($sformatf("starve_i%0d", k), instr_gnt, k == 4);
      commitCycle();
    end
    doCycle(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Out-of-range read.
    applyStimulus(1, 0, 32'h0, 1, 0, 4'h0, 32'h0000_4000, 32'h0);
    checkOutput("oor_gnt", data_gnt, 1'b1);
    checkOutput("oor_en", ram_en, 1'b0);
    commitCycle();
    applyStimulus(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("oor_err", data_err, 1'b1);
    checkOutput("oor_rdata", data_rdata, 32'h0);
    commitCycle();

    // Reset the cycle after a grant: the response is dropped.
    doCycle(1, 1, 32'h44, 0, 0, 4'h0, 32'h0, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("rst_drop", instr_rvalid, 1'b0);
    commitCycle();
    doCycle(1, 1, 32'h48, 0, 0, 4'h0, 32'h0, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      doCycle(($urandom_range(0, 49) != 0), $urandom_range(0, 2) != 0, randAddr(),
              $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              4'($urandom), randAddr(), $urandom);
    end
    doCycle(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
